// File: rtl/raybox_spi_pkg.sv
// raybox_spi_pkg: shared widths, FSM state encoding and raybox register command codes.
// Used by the SPI master (raybox_spi_master_tx) and by receiver-side bench models.
package raybox_spi_pkg;
    localparam int DEF_CMD_W  = 4;
    localparam int DEF_DATA_W = 24;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        SETUP    = S_SETUP,
        SHIFT_HI = S_SHIFT_HI,
        SHIFT_LO = S_SHIFT_LO,
        HOLD     = S_HOLD,
        GAP      = S_GAP
    } state_t;

    localparam logic [3:0] CMD_SKY     = 4'h0;
    localparam logic [3:0] CMD_FLOOR   = 4'h1;
    localparam logic [3:0] CMD_LEAK    = 4'h2;
    localparam logic [3:0] CMD_OTHER   = 4'h3;
    localparam logic [3:0] CMD_VSHIFT  = 4'h4;
    localparam logic [3:0] CMD_VINF    = 4'h5;
    localparam logic [3:0] CMD_MAPD    = 4'h6;
    localparam logic [3:0] CMD_TEXADD0 = 4'h7;
    localparam logic [3:0] CMD_TEXADD1 = 4'h8;
    localparam logic [3:0] CMD_TEXADD2 = 4'h9;
    localparam logic [3:0] CMD_TEXADD3 = 4'hA;
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: down-counter that reloads on phase entry and flags terminal count.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - reload the counter with load_val (asserted on the edge entering a phase)
//   load_val  - phase length minus one
//   tc        - high in the last cycle of the current phase
module spi_half_period_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign tc = cnt == '0;
endmodule

// File: rtl/raybox_spi_master_tx.sv
// raybox_spi_master_tx: SPI mode-0 master sending {command, payload} frames MSB-first.
// Ports:
//   i_clk, i_reset     - clock, asynchronous active-high reset
//   i_valid / o_ready  - frame handshake; inputs sampled only on the accept cycle
//   i_cmd, i_data      - command field and right-aligned payload
//   i_len              - payload bit count, clamped to DATA_W
//   i_abort            - drop the frame in flight (ignored in IDLE and GAP)
//   o_csb, o_sclk, o_mosi - registered SPI pins
//   o_busy, o_done     - frame in progress / one-cycle normal completion pulse
module raybox_spi_master_tx
    import raybox_spi_pkg::*;
#(
    parameter int CMD_W      = DEF_CMD_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = 5,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_busy,
    output logic              o_done
);
    localparam int SR_W = CMD_W + DATA_W;
    localparam int BW   = $clog2(SR_W + 1);
    localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [LEN_W-1:0] DW_L = LEN_W'(DATA_W);

    state_t          state, nxt;
    logic [SR_W-1:0] sr, sr_nxt;
    logic [BW-1:0]   bits, bits_nxt;
    logic [LEN_W-1:0] len_c;
    logic [TW-1:0]   load_val;
    logic            load, tc, accept, abort_go, last_bit, shift_end, active_nxt;

    assign len_c     = (i_len > DW_L) ? DW_L : i_len;
    assign accept    = state == IDLE && i_valid;
    assign abort_go  = i_abort && state != IDLE && state != GAP;
    assign last_bit  = bits == BW'(1);
    assign shift_end = state == SHIFT_HI && tc;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:             nxt = i_valid ? SETUP : IDLE;
            SETUP, SHIFT_LO:  nxt = tc ? SHIFT_HI : state;
            SHIFT_HI:         nxt = tc ? (last_bit ? HOLD : SHIFT_LO) : SHIFT_HI;
            HOLD:             nxt = tc ? GAP : HOLD;
            GAP:              nxt = tc ? IDLE : GAP;
            default:          nxt = IDLE;
        endcase
        if (abort_go) nxt = GAP;
    end

    // Every phase is a distinct state, so a state change marks a phase entry.
    assign load     = nxt != state;
    assign load_val = (nxt == GAP) ? TW'(GAP_CYCLES - 1) : TW'(CLK_DIV - 1);

    // Payload is left-justified under the command so the frame always leaves from the top bit.
    assign sr_nxt   = accept ? {i_cmd, i_data << (DW_L - len_c)} :
                      (shift_end && !last_bit) ? sr << 1 : sr;
    assign bits_nxt = accept ? BW'(CMD_W) + BW'(len_c) : shift_end ? bits - 1'b1 : bits;
    assign active_nxt = nxt != IDLE && nxt != GAP;

    spi_half_period_timer #(.W(TW)) u_timer (
        .clk(i_clk),
        .rst(i_reset),
        .load(load),
        .load_val(load_val),
        .tc(tc)
    );

    // Pins are registered from the next state so they change together with it.
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state   <= IDLE;
            sr      <= '0;
            bits    <= '0;
            o_csb   <= 1'b1;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= nxt;
            sr      <= sr_nxt;
            bits    <= bits_nxt;
            o_csb   <= !active_nxt;
            o_sclk  <= nxt == SHIFT_HI;
            o_mosi  <= active_nxt && sr_nxt[SR_W-1];
            o_ready <= nxt == IDLE;
            o_busy  <= nxt != IDLE;
            o_done  <= state == HOLD && tc && !abort_go;
        end
endmodule

// File: tb/tb_raybox_spi_master_tx.sv
// tb_raybox_spi_master_tx: directed frames against a cycle-position model of the SPI waveform.
module tb_raybox_spi_master_tx;
    import raybox_spi_pkg::*;

    localparam int CW = DEF_CMD_W;
    localparam int DW = DEF_DATA_W;
    localparam int LW = 5;
    localparam int G  = 4;

    logic clk = 1'b0, rst = 1'b1, valid = 1'b0, abort = 1'b0, sel = 1'b0;
    logic [CW-1:0] cmd = '0;
    logic [DW-1:0] data = '0;
    logic [LW-1:0] len = '0;
    logic [5:0] o0, o1, act; // {csb,sclk,mosi,ready,busy,done}
    logic csb, sclk, mosi, ready, busy, done;

    always #5 clk = ~clk;

    raybox_spi_master_tx #(.CMD_W(CW), .DATA_W(DW), .LEN_W(LW), .CLK_DIV(2), .GAP_CYCLES(G)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid & ~sel), .o_ready(o0[2]),
        .i_cmd(cmd), .i_data(data), .i_len(len), .i_abort(abort & ~sel),
        .o_csb(o0[5]), .o_sclk(o0[4]), .o_mosi(o0[3]), .o_busy(o0[1]), .o_done(o0[0])
    );

    raybox_spi_master_tx #(.CMD_W(CW), .DATA_W(DW), .LEN_W(LW), .CLK_DIV(1), .GAP_CYCLES(G)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid & sel), .o_ready(o1[2]),
        .i_cmd(cmd), .i_data(data), .i_len(len), .i_abort(abort & sel),
        .o_csb(o1[5]), .o_sclk(o1[4]), .o_mosi(o1[3]), .o_busy(o1[1]), .o_done(o1[0])
    );

    assign act = sel ? o1 : o0;
    assign {csb, sclk, mosi, ready, busy, done} = act;

    // Model: t counts cycles since accept (0 = idle); csb is low for t in [1, gap_at),
    // GAP lasts G cycles from gap_at, each bit occupies two CLK_DIV-long phases.
    int t = 0, gap_at = 0, n_bits = 1, cdiv = 2, l_m = 0;
    bit aborted = 1'b0;
    logic fbits [0:CW+DW-1];

    always @(posedge clk or posedge rst) begin
        if (rst) t = 0;
        else if (t == 0) begin
            if (valid) begin
                l_m = (int'(len) > DW) ? DW : int'(len);
                n_bits = CW + l_m;
                for (int k = 0; k < n_bits; k++)
                    fbits[k] = (k < CW) ? cmd[CW-1-k] : data[l_m-1-(k-CW)];
                cdiv = sel ? 1 : 2;
                gap_at = cdiv * (2 * n_bits + 1) + 1;
                aborted = 1'b0;
                t = 1;
            end
        end else begin
            if (abort && t < gap_at) begin
                aborted = 1'b1;
                gap_at = t + 1;
            end
            t = t + 1;
            if (t == gap_at + G) t = 0;
        end
    end

    int n_chk = 0, n_fail = 0;
    int low = 0, edges = 0, dones = 0, since_rise = 0, rdy_gap = 0, fall_gap = 0, frames = 0;
    logic [63:0] rx = '0;
    logic pcsb = 1'b1, psclk = 1'b0, pready = 1'b1;
    bit done_on_rise = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one cycle, compare every pin with the model, then record the slave's view.
    task automatic tick();
        logic [5:0] e;
        int p;
        @(negedge clk);
        if (t == 0) e = 6'b100100;
        else if (t >= gap_at) e = {5'b10001, (t == gap_at) && !aborted};
        else begin
            p = (t - 1) / cdiv;
            e = {1'b0, p[0], fbits[(p / 2 < n_bits - 1) ? p / 2 : n_bits - 1], 3'b010};
        end
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL pins t=%0d {csb,sclk,mosi,ready,busy,done}: got %b expected %b", t, act, e);
        end
        if (!csb && pcsb) begin
            low = 0; edges = 0; dones = 0; rx = '0; frames++; fall_gap = since_rise + 1;
        end
        if (csb && !pcsb) since_rise = 0; else since_rise++;
        if (!csb) low++;
        if (!csb && sclk && !psclk) begin edges++; rx = {rx[62:0], mosi}; end
        if (done) begin dones++; done_on_rise = csb && !pcsb; end
        if (ready && !pready) rdy_gap = since_rise;
        pcsb = csb; psclk = sclk; pready = ready;
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [LW-1:0] l);
        cmd = c; data = d; len = l; valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin tick(); n++; end while (!(ready && csb) && n < 2000);
        chk("idle_reached", {63'b0, ready && csb}, 64'd1);
    endtask

    initial begin
        tick(); tick();
        chk("reset_pins", act, 6'b100100);
        rst = 1'b0;
        tick();

        // 1: async reset on the 10th csb-low cycle
        send(4'h5, 24'hABCDEF, 5'd24);
        for (int n = 0; n < 100 && low < 10; n++) tick();
        chk("rst_reached_10", 64'(low), 64'd10);
        rst = 1'b1;
        #1;
        chk("rst_async_csb", {63'b0, csb}, 64'd1);
        chk("rst_async_sclk", {63'b0, sclk}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", {63'b0, ready}, 64'd1);
        chk("rst_no_done", 64'(dones), 64'd0);

        // 2: full 28-bit frame at CLK_DIV=2
        send(CMD_VINF, 24'hABCDEF, 5'd24);
        wait_idle();
        chk("f2_edges", 64'(edges), 64'd28);
        chk("f2_bits", rx, 64'h5ABCDEF);
        chk("f2_csb_low", 64'(low), 64'd114);
        chk("f2_done_count", 64'(dones), 64'd1);
        chk("f2_done_on_rise", {63'b0, done_on_rise}, 64'd1);
        chk("f2_ready_gap", 64'(rdy_gap), 64'd4);

        // 3: command-only frame at CLK_DIV=1
        sel = 1'b1;
        tick();
        send(CMD_TEXADD3, 24'h123456, 5'd0);
        wait_idle();
        chk("f3_edges", 64'(edges), 64'd4);
        chk("f3_bits", rx, 64'hA);
        chk("f3_csb_low", 64'(low), 64'd9);
        sel = 1'b0;
        tick();

        // 4: over-range length clamps to 24 payload bits
        send(CMD_SKY, 24'h000001, 5'd31);
        wait_idle();
        chk("f4_edges", 64'(edges), 64'd28);
        chk("f4_last_bit", {63'b0, rx[0]}, 64'd1);
        chk("f4_bits", rx, 64'h0000001);

        // 5: abort after the 3rd rising edge, then a clean frame
        send(4'hC, 24'hFFFFFF, 5'd24);
        for (int n = 0; n < 200 && edges < 3; n++) tick();
        chk("f5_reached_3", 64'(edges), 64'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("f5_abort_csb", {63'b0, csb}, 64'd1);
        wait_idle();
        chk("f5_no_done", 64'(dones), 64'd0);
        chk("f5_edges", 64'(edges), 64'd3);
        chk("f5_ready_gap", 64'(rdy_gap), 64'(G));
        send(CMD_OTHER, 24'h0000A5, 5'd8);
        wait_idle();
        chk("f5b_edges", 64'(edges), 64'd12);
        chk("f5b_bits", rx, 64'h3A5);

        // 6: back-to-back with valid held high
        begin
            int f0;
            f0 = frames;
            cmd = CMD_FLOOR; data = 24'h000012; len = 5'd8; valid = 1'b1;
            for (int n = 0; n < 50 && frames < f0 + 1; n++) tick();
            cmd = CMD_LEAK; data = 24'h000034;
            for (int n = 0; n < 400 && frames < f0 + 2; n++) tick();
            valid = 1'b0;
            wait_idle();
            for (int n = 0; n < 30; n++) tick();
            chk("b2b_frames", 64'(frames - f0), 64'd2);
            chk("b2b_bits", rx, 64'h234);
            chk("b2b_gap_ok", {63'b0, fall_gap >= G + 1}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/raybox_spi_master_tx.md
Name: raybox_spi_master_tx

Overview:
Serial SPI master that drives the register/vector SPI inputs of top_raybox_zero_fsm (csb, sclk, mosi) from on-chip sources such as LA-driven or Wishbone-driven test logic. It is the transmitting end of the raybox register-load protocol. It accepts one frame per valid/ready handshake: a command nibble plus a variable-length payload, sent MSB-first in SPI mode 0. It sits beside the design mux, and its outputs are muxed onto the raybox reg/vec SPI pins.

Parameters:
CMD_W, 4, command field width in bits, sent first.
DATA_W, 24, maximum payload width in bits.
LEN_W, 5, width of i_len; must satisfy 2^LEN_W > DATA_W.
CLK_DIV, 2, SCLK half-period in i_clk cycles; must be >= 1.
GAP_CYCLES, 4, minimum csb-high cycles between frames; must be >= 1.

Ports:
i_clk    input   1        system clock.
i_reset  input   1        asynchronous, active-high reset.
i_valid  input   1        frame request.
o_ready  output  1        idle and able to accept a frame.
i_cmd    input   CMD_W    command field.
i_data   input   DATA_W   payload, right-aligned (LSBs valid).
i_len    input   LEN_W    number of payload bits to send (0..DATA_W).
i_abort  input   1        synchronous frame abort.
o_csb    output  1        SPI chip select, active low.
o_sclk   output  1        SPI clock, idles low.
o_mosi   output  1        SPI data.
o_busy   output  1        high from frame accept until o_ready reasserts.
o_done   output  1        one-cycle pulse on normal frame completion.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; o_csb=1, o_sclk=0, o_mosi=0, o_ready=1, o_busy=0, o_done=0. Reset mid-frame: csb rises immediately; no o_done.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP. A half-period counter counts CLK_DIV cycles per phase.
- IDLE: o_ready=1. On i_valid && o_ready, latch the frame:
  - Shift register = {i_cmd, i_data << (DATA_W - L)}, where L = min(i_len, DATA_W). i_len > DATA_W is clamped.
  - Bits remaining N = CMD_W + L. L=0 gives a command-only frame.
  - Next cycle: o_csb=0, o_mosi = frame MSB, o_ready=0, o_busy=1. Enter SETUP.
- SETUP: sclk low for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: o_sclk=1 for CLK_DIV cycles; the slave samples on the rising edge.
  - If this is not the last bit: go to SHIFT_LO, with o_sclk=0 and o_mosi advancing to the next bit in the same cycle.
  - If this is the last bit: go to HOLD with o_sclk=0 and o_mosi unchanged.
- SHIFT_LO: CLK_DIV cycles, then go to SHIFT_HI.
- HOLD: sclk low, csb low, for CLK_DIV cycles. Then o_csb=1, o_mosi=0, o_done pulses for exactly that one cycle, and the block enters GAP.
- GAP: csb high for GAP_CYCLES cycles. Then go to IDLE: o_ready=1, o_busy=0.
- Frame timing: csb is low for exactly CLK_DIV*(2N+1) cycles, and there are exactly N rising edges of sclk.
- o_sclk is never high while o_csb=1. o_mosi is stable from CLK_DIV cycles before each rising edge until the following falling edge.
- i_abort in any state other than IDLE or GAP: next cycle o_csb=1, o_sclk=0, o_mosi=0, enter GAP; no o_done. i_abort in IDLE or GAP has no effect.
- i_valid asserted while o_ready=0 is ignored. Inputs are sampled only at the accept cycle.
- Simultaneous i_valid and i_abort in IDLE: the frame is accepted and the abort is ignored.
- All outputs are registered (no combinational path from input to pin).

Decomposition:
- Package raybox_spi_pkg: CMD_W default, a state enum type (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP), and the raybox register command code constants shared with the receiver-side testbench model.
- One natural sub-module, spi_half_period_timer: a counter that reloads to CLK_DIV-1 on phase entry and raises a terminal-count strobe.
- Shift register, bit counter and FSM stay in the top block.

Test Plan:
1. Reset mid-frame: assert i_reset at the 10th csb-low cycle -> o_csb=1 and o_sclk=0 in the same cycle (async); o_ready=1 after release; no o_done.
2. CLK_DIV=2, i_cmd=4'h5, i_data=24'hABCDEF, i_len=24 -> 28 rising sclk edges sampling 0101_1010_1011_1100_1101_1110_1111; csb low for 114 cycles; o_done pulses once, on the csb-rise cycle; o_ready returns 4 cycles later.
3. i_len=0, i_cmd=4'hA, CLK_DIV=1 -> 4 edges sampling 1010; csb low for 9 cycles.
4. i_len=31 (over range), i_data=24'h000001 -> clamped to 24 payload bits; 28 edges; last sampled bit is 1.
5. i_abort asserted after the 3rd rising edge -> csb high next cycle; no o_done; o_ready returns after GAP_CYCLES; a following frame with cmd=4'h3 and len=8 is sent correctly.
6. Back-to-back: i_valid held high with two frames queued by the bench -> second csb fall no earlier than GAP_CYCLES+1 cycles after the first csb rise; i_valid during busy is ignored (exactly 2 frames sent).
